// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the multiplexed 7-segment display path: character
// width, character codes understood by the shared decoder, and the scheduler
// state encoding.
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int CHAR_W = 5;

    // Character codes: 0-9 then A-V, matching the shared decoder table.
    localparam logic [CHAR_W-1:0]
        CH_0 = 5'd0,  CH_1 = 5'd1,  CH_2 = 5'd2,  CH_3 = 5'd3,
        CH_4 = 5'd4,  CH_5 = 5'd5,  CH_6 = 5'd6,  CH_7 = 5'd7,
        CH_8 = 5'd8,  CH_9 = 5'd9,  CH_A = 5'd10, CH_B = 5'd11,
        CH_C = 5'd12, CH_D = 5'd13, CH_E = 5'd14, CH_F = 5'd15,
        CH_G = 5'd16, CH_H = 5'd17, CH_I = 5'd18, CH_J = 5'd19,
        CH_K = 5'd20, CH_L = 5'd21, CH_M = 5'd22, CH_N = 5'd23,
        CH_O = 5'd24, CH_P = 5'd25, CH_Q = 5'd26, CH_R = 5'd27,
        CH_S = 5'd28, CH_T = 5'd29, CH_U = 5'd30, CH_V = 5'd31;

    // The 5-bit code space is full; the decoder renders the top code with
    // all segments off, so blank shares its value with CH_V.
    localparam logic [CHAR_W-1:0] CH_BLANK = CH_V;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        SHOW  = 2'd2
    } state_t;

endpackage

// File: rtl/seg_display_scheduler_if.sv
// -----------------------------------------------------------------------------
// seg_display_scheduler_if
// Character write port of the display scheduler (valid/ready handshake).
//   wr_valid : source has a character
//   wr_ready : scheduler accepts (transfer when wr_valid & wr_ready)
//   wr_char  : character code
//   wr_last  : final character of the message
// master = message source, slave = scheduler.
// -----------------------------------------------------------------------------
interface seg_display_scheduler_if;
    import seg_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [CHAR_W-1:0] wr_char;
    logic              wr_last;

    modport master (output wr_valid, output wr_char, output wr_last, input wr_ready);
    modport slave  (input wr_valid, input wr_char, input wr_last, output wr_ready);

endinterface

// File: rtl/seg_refresh_timer.sv
// -----------------------------------------------------------------------------
// seg_refresh_timer
// Digit-slot timebase for the multiplexed display.
//   clk, reset  : clock, synchronous active-high reset
//   slot_last   : last cycle of the current digit slot
//   digit_idx   : digit currently owning the slot
//   digit_next  : digit that owns the following slot
//   in_blank    : inside the anti-ghost window at the start of the slot
//   frame_tick  : one-cycle pulse in the first cycle of digit 0's slot
// -----------------------------------------------------------------------------
module seg_refresh_timer #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    localparam int unsigned SLOT_W = $clog2(REFRESH_DIV),
    localparam int unsigned DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic             slot_last,
    output logic [DIG_W-1:0] digit_idx,
    output logic [DIG_W-1:0] digit_next,
    output logic             in_blank,
    output logic             frame_tick
);

    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [DIG_W-1:0]  digit_idx_q, digit_idx_d;
    logic              frame_tick_q, frame_tick_d;
    logic              last_digit;

    always_comb begin
        slot_last    = (slot_cnt_q == SLOT_W'(REFRESH_DIV - 1));
        last_digit   = (digit_idx_q == DIG_W'(NUM_DIGITS - 1));
        digit_next   = last_digit ? '0 : digit_idx_q + DIG_W'(1);
        slot_cnt_d   = slot_last ? '0 : slot_cnt_q + SLOT_W'(1);
        digit_idx_d  = slot_last ? digit_next : digit_idx_q;
        // Registered so the pulse lines up with digit_idx becoming 0.
        frame_tick_d = slot_last && last_digit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_q   <= '0;
            digit_idx_q  <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            digit_idx_q  <= digit_idx_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign digit_idx  = digit_idx_q;
    assign in_blank   = (slot_cnt_q < SLOT_W'(BLANK_CYCLES));
    assign frame_tick = frame_tick_q;

endmodule

// File: rtl/seg_display_scheduler.sv
// -----------------------------------------------------------------------------
// seg_display_scheduler
// Time-multiplexes one shared char-code -> 7-seg decoder across NUM_DIGITS
// common-anode digits. Holds a message buffer loaded through a valid/ready
// write port and optionally scrolls it right-to-left.
//   clk, reset : clock, synchronous active-high reset
//   wr         : character write port (slave side of seg_display_scheduler_if)
//   scroll_en  : level, scroll when the message is longer than the display
//   char       : registered code for the shared decoder
//   an         : active-low anode enables, an[NUM_DIGITS-1] = leftmost
//   frame_tick : one-cycle pulse when the digit index wraps to 0
// -----------------------------------------------------------------------------
module seg_display_scheduler
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter int unsigned BLANK_CYCLES  = 500,
    parameter int unsigned MSG_DEPTH     = 16,
    parameter int unsigned SCROLL_FRAMES = 250
) (
    input  logic                     clk,
    input  logic                     reset,
    seg_display_scheduler_if.slave   wr,
    input  logic                     scroll_en,
    output logic [CHAR_W-1:0]        char,
    output logic [NUM_DIGITS-1:0]    an,
    output logic                     frame_tick
);

    localparam int unsigned AW    = $clog2(MSG_DEPTH);
    localparam int unsigned PTR_W = AW + 1;
    localparam int unsigned P_W   = PTR_W + 1;
    localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned FC_W  = $clog2(SCROLL_FRAMES + 1);

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  msg_len_q, msg_len_d;
    logic [PTR_W-1:0]  scroll_ptr_q, scroll_ptr_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CHAR_W-1:0] char_q, char_d;
    logic [CHAR_W-1:0] msg_buf_q [MSG_DEPTH];
    logic [CHAR_W-1:0] msg_buf_d [MSG_DEPTH];

    logic              slot_last;
    logic [DIG_W-1:0]  digit_idx;
    logic [DIG_W-1:0]  digit_next;
    logic              in_blank;

    logic              wr_fire;
    logic [PTR_W-1:0]  wr_addr;
    logic [PTR_W-1:0]  wr_count;
    logic              wr_done;
    logic              scroll_go;
    logic [P_W-1:0]    pos_now;
    logic [P_W-1:0]    pos_next;
    logic              digit_lit;

    seg_refresh_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .slot_last  (slot_last),
        .digit_idx  (digit_idx),
        .digit_next (digit_next),
        .in_blank   (in_blank),
        .frame_tick (frame_tick)
    );

    // Message position shown on a digit; one extra bit so the sum cannot wrap.
    function automatic logic [P_W-1:0] digit_pos(input logic [DIG_W-1:0] digit,
                                                 input logic [PTR_W-1:0] ptr);
        return P_W'(ptr) + P_W'(NUM_DIGITS - 1) - P_W'(digit);
    endfunction

    // Position never exceeds 2*msg_len-1, so a single subtract wraps it.
    function automatic logic [AW-1:0] wrap_index(input logic [P_W-1:0] pos,
                                                 input logic [PTR_W-1:0] len);
        logic [P_W-1:0] idx;
        idx = (pos >= P_W'(len)) ? pos - P_W'(len) : pos;
        return AW'(idx);
    endfunction

    assign wr.wr_ready = 1'b1;
    assign wr_fire     = wr.wr_valid;

    // Load / scroll control. A write in any state restarts the message at
    // entry 0 except in LOAD, and takes priority over a same-cycle scroll step.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        msg_len_d    = msg_len_q;
        scroll_ptr_d = scroll_ptr_q;
        frame_cnt_d  = frame_cnt_q;
        msg_buf_d    = msg_buf_q;

        wr_addr   = (state_q == LOAD) ? wr_ptr_q : '0;
        wr_count  = wr_addr + PTR_W'(1);
        wr_done   = wr.wr_last || (wr_count == PTR_W'(MSG_DEPTH));
        scroll_go = (state_q == SHOW) && scroll_en && frame_tick &&
                    (msg_len_q > PTR_W'(NUM_DIGITS));

        if (wr_fire) begin
            msg_buf_d[AW'(wr_addr)] = wr.wr_char;
            wr_ptr_d     = wr_count;
            scroll_ptr_d = '0;
            frame_cnt_d  = '0;
            if (wr_done) begin
                state_d   = SHOW;
                msg_len_d = wr_count;
            end else begin
                state_d = LOAD;
            end
        end else if (scroll_go) begin
            if (frame_cnt_q == FC_W'(SCROLL_FRAMES - 1)) begin
                frame_cnt_d  = '0;
                scroll_ptr_d = (scroll_ptr_q == msg_len_q - PTR_W'(1)) ?
                               '0 : scroll_ptr_q + PTR_W'(1);
            end else begin
                frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
        end
    end

    // Character fetch for the upcoming slot and anode drive for the current one.
    always_comb begin
        pos_now   = digit_pos(digit_idx, scroll_ptr_q);
        pos_next  = digit_pos(digit_next, scroll_ptr_q);
        char_d    = slot_last ? msg_buf_q[wrap_index(pos_next, msg_len_q)] : char_q;
        // Short messages never scroll, so positions past the end stay dark.
        digit_lit = !((msg_len_q < PTR_W'(NUM_DIGITS)) && (pos_now >= P_W'(msg_len_q)));
        an = '1;
        if ((state_q == SHOW) && !in_blank && digit_lit) begin
            an[digit_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            wr_ptr_q     <= '0;
            msg_len_q    <= '0;
            scroll_ptr_q <= '0;
            frame_cnt_q  <= '0;
            char_q       <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            msg_len_q    <= msg_len_d;
            scroll_ptr_q <= scroll_ptr_d;
            frame_cnt_q  <= frame_cnt_d;
            char_q       <= char_d;
        end
    end

    // Buffer contents are only meaningful once written, so no reset.
    always_ff @(posedge clk) begin
        msg_buf_q <= msg_buf_d;
    end

    assign char = char_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// -----------------------------------------------------------------------------
// tb_seg_display_scheduler
// Directed, table-driven bench for seg_display_scheduler with a small
// configuration (4 digits, 8-cycle slots, 2 blank cycles, 8-entry buffer,
// scroll every 2 frames).
// -----------------------------------------------------------------------------
module tb_seg_display_scheduler;
    import seg_pkg::*;

    typedef struct packed {
        logic [3:0]      len;
        logic [7:0][4:0] msg;
        logic            scroll;
        logic [3:0]      lit;
        logic [3:0][4:0] exp_ch;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scroll_en = 1'b0;
    logic [4:0] char;
    logic [3:0] an;
    logic       frame_tick;

    int checks = 0;
    int failures = 0;

    vec_t vecs [7];

    seg_display_scheduler_if wr_bus ();

    seg_display_scheduler #(
        .NUM_DIGITS    (4),
        .REFRESH_DIV   (8),
        .BLANK_CYCLES  (2),
        .MSG_DEPTH     (8),
        .SCROLL_FRAMES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr_bus),
        .scroll_en  (scroll_en),
        .char       (char),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Lands on a negedge where frame_tick is high; now=1 accepts the current cycle.
    task automatic wait_tick(input bit now);
        int n;
        n = 0;
        if (!now) @(negedge clk);
        while (!frame_tick && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("tick_wait", {31'd0, frame_tick}, 32'd1);
    endtask

    task automatic load_msg(input int n, input logic [7:0][4:0] m, input bit with_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("wr_ready", {31'd0, wr_bus.wr_ready}, 32'd1);
            wr_bus.wr_valid = 1'b1;
            wr_bus.wr_char  = m[i];
            wr_bus.wr_last  = with_last && (i == n - 1);
        end
        @(negedge clk);
        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_last  = 1'b0;
    endtask

    // Called on a frame_tick negedge (k=0); checks all 32 cycles of the frame.
    task automatic sample_frame(input string name, input logic [3:0] lit,
                                input logic [3:0][4:0] ec);
        for (int k = 0; k < 32; k++) begin
            int d;
            int s;
            logic [3:0] e;
            if (k > 0) @(negedge clk);
            d = k / 8;
            s = k % 8;
            e = 4'hF;
            if (s >= 2 && lit[d]) e[d] = 1'b0;
            chk($sformatf("%s an k=%0d", name, k), {28'd0, an}, {28'd0, e});
            chk($sformatf("%s tick k=%0d", name, k), {31'd0, frame_tick}, {31'd0, (k == 0)});
            if (e != 4'hF)
                chk($sformatf("%s char k=%0d", name, k), {27'd0, char}, {27'd0, ec[d]});
        end
    endtask

    initial begin
        int n;
        int ptr;

        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_char  = '0;
        wr_bus.wr_last  = 1'b0;

        vecs[0] = '{len: 4'd4, msg: {5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd3, 5'd2, 5'd1},
                    scroll: 1'b0, lit: 4'b1111, exp_ch: {5'd1, 5'd2, 5'd3, 5'd4}};
        vecs[1] = '{len: 4'd2, msg: {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2, 5'd1},
                    scroll: 1'b1, lit: 4'b1100, exp_ch: {5'd1, 5'd2, 5'd0, 5'd0}};
        vecs[2] = '{len: 4'd6, msg: {5'd0, 5'd0, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0},
                    scroll: 1'b0, lit: 4'b1111, exp_ch: {5'd0, 5'd1, 5'd2, 5'd3}};
        vecs[3] = '{len: 4'd5, msg: {5'd0, 5'd0, 5'd0, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10},
                    scroll: 1'b0, lit: 4'b1111, exp_ch: {5'd10, 5'd11, 5'd12, 5'd13}};
        vecs[4] = '{len: 4'd3, msg: {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd9, 5'd8, 5'd7},
                    scroll: 1'b1, lit: 4'b1110, exp_ch: {5'd7, 5'd8, 5'd9, 5'd0}};
        vecs[5] = '{len: 4'd1, msg: {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31},
                    scroll: 1'b0, lit: 4'b1000, exp_ch: {5'd31, 5'd0, 5'd0, 5'd0}};
        vecs[6] = '{len: 4'd8, msg: {5'd27, 5'd26, 5'd25, 5'd24, 5'd23, 5'd22, 5'd21, 5'd20},
                    scroll: 1'b0, lit: 4'b1111, exp_ch: {5'd20, 5'd21, 5'd22, 5'd23}};

        // Reset held for 3 cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_char", {27'd0, char}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_bus.wr_ready}, 32'd1);
        chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(EMPTY));
        reset = 1'b0;

        // No anode may light without a message.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk($sformatf("idle_an c=%0d", i), {28'd0, an}, 32'hF);
        end

        // Frame period: 4 digits x 8 cycles.
        wait_tick(1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 100);
        chk("frame_period", n, 32'd32);

        // Table-driven messages, each loaded over the previous one in SHOW.
        for (int v = 0; v < 7; v++) begin
            scroll_en = vecs[v].scroll;
            load_msg(int'(vecs[v].len), vecs[v].msg, 1'b1);
            wait_tick(1'b1);
            for (int f = 0; f < 3; f++) begin
                wait_tick(1'b0);
                sample_frame($sformatf("vec%0d f%0d", v, f), vecs[v].lit, vecs[v].exp_ch);
            end
        end

        // Scroll 0..5: leftmost steps every second frame, wrapping 5 -> 0.
        scroll_en = 1'b1;
        load_msg(6, {5'd0, 5'd0, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}, 1'b1);
        for (int f = 1; f <= 14; f++) begin
            wait_tick(f == 1);
            ptr = (f / 2) % 6;
            repeat (2) @(negedge clk);
            if ((f % 2) == 1 && f >= 3) begin
                chk($sformatf("scroll f%0d d0_an", f), {28'd0, an}, 32'hE);
                chk($sformatf("scroll f%0d d0_char", f), {27'd0, char}, (ptr + 3) % 6);
            end
            repeat (24) @(negedge clk);
            chk($sformatf("scroll f%0d d3_an", f), {28'd0, an}, 32'h7);
            chk($sformatf("scroll f%0d d3_char", f), {27'd0, char}, ptr);
        end

        // scroll_en low freezes the position.
        scroll_en = 1'b0;
        for (int f = 15; f <= 18; f++) begin
            wait_tick(1'b0);
            repeat (26) @(negedge clk);
            chk($sformatf("freeze f%0d d3_an", f), {28'd0, an}, 32'h7);
            chk($sformatf("freeze f%0d d3_char", f), {27'd0, char}, 32'd1);
        end

        // Write lands on the same edge as a scroll step: write wins.
        scroll_en = 1'b1;
        load_msg(6, {5'd0, 5'd0, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}, 1'b1);
        wait_tick(1'b1);
        wait_tick(1'b0);
        chk("pre_step frame_cnt", 32'(dut.frame_cnt_q), 32'd1);
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_char  = 5'd9;
        wr_bus.wr_last  = 1'b0;
        @(negedge clk);
        wr_bus.wr_valid = 1'b0;
        chk("race an", {28'd0, an}, 32'hF);
        chk("race state", 32'(dut.state_q), 32'(LOAD));
        chk("race scroll_ptr", 32'(dut.scroll_ptr_q), 32'd0);
        chk("race frame_cnt", 32'(dut.frame_cnt_q), 32'd0);
        chk("race wr_ptr", 32'(dut.wr_ptr_q), 32'd1);

        // Finish that message (9,1,2,3) and reset while digit 1 is lit.
        load_msg(3, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd2, 5'd1}, 1'b1);
        scroll_en = 1'b0;
        chk("cont msg_len", 32'(dut.msg_len_q), 32'd4);
        wait_tick(1'b1);
        wait_tick(1'b0);
        repeat (10) @(negedge clk);
        chk("pre_rst an", {28'd0, an}, 32'hD);
        chk("pre_rst char", {27'd0, char}, 32'd2);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst an", {28'd0, an}, 32'hF);
        chk("mid_rst state", 32'(dut.state_q), 32'(EMPTY));
        chk("mid_rst msg_len", 32'(dut.msg_len_q), 32'd0);
        chk("mid_rst wr_ptr", 32'(dut.wr_ptr_q), 32'd0);
        chk("mid_rst char", {27'd0, char}, 32'd0);
        chk("mid_rst frame_tick", {31'd0, frame_tick}, 32'd0);
        reset = 1'b0;

        // Eight writes without wr_last fill the buffer and show it.
        load_msg(8, {5'd17, 5'd16, 5'd15, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10}, 1'b0);
        chk("auto state", 32'(dut.state_q), 32'(SHOW));
        chk("auto msg_len", 32'(dut.msg_len_q), 32'd8);
        wait_tick(1'b1);
        wait_tick(1'b0);
        sample_frame("auto", 4'b1111, {5'd10, 5'd11, 5'd12, 5'd13});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
